// File: rtl/cmd_assembler_pkg.sv
// Types and constants shared by the command assembler and the command processor.
// Opcodes sit in the upper nibble of the 16-bit command word.
package cmd_assembler_pkg;

   typedef enum logic {WAIT_HI = 1'b0, WAIT_LO = 1'b1} rx_state_t;
   typedef enum logic {TX_IDLE = 1'b0, TX_WAIT = 1'b1} tx_state_t;

   localparam logic [7:0] RESP_ACK_DEFAULT = 8'hA5;

   localparam logic [3:0] OP_CAL     = 4'h0;
   localparam logic [3:0] OP_MOVE    = 4'h2;
   localparam logic [3:0] OP_MOVE_FF = 4'h3;
   localparam logic [3:0] OP_TOUR    = 4'h4;

endpackage

// File: rtl/cmd_assembler_tx.sv
// Response transmitter: turns send_resp pulses into single-byte acknowledge
// transmissions, buffering at most one request while a byte is in flight.
module resp_tx_ctrl
   import cmd_assembler_pkg::*;
#(
   parameter logic [7:0] RESP_ACK = RESP_ACK_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_resp,
   input  logic       tx_done,
   output logic       trmt,
   output logic [7:0] tx_data,
   output logic       resp_busy
);

   tx_state_t  state_r, state_s;
   logic       pending_r, pending_s;
   logic       trmt_r, trmt_s;
   logic       busy_r, busy_s;
   logic [7:0] tx_data_r;
   logic       done_s;

   // Next-state logic; a level tx_done left over from the previous byte is
   // ignored during the trmt cycle, before the UART has had a chance to clear it.
   always_comb begin
      state_s   = state_r;
      pending_s = pending_r;
      trmt_s    = 1'b0;
      done_s    = tx_done & ~trmt_r;
      case (state_r)
         TX_IDLE: begin
            if (send_resp | pending_r) begin
               trmt_s    = 1'b1;
               pending_s = 1'b0;
               state_s   = TX_WAIT;
            end else begin
               state_s   = TX_IDLE;
            end
         end
         TX_WAIT: begin
            if (send_resp) begin
               pending_s = 1'b1;
            end else begin
               pending_s = pending_r;
            end
            if (done_s) begin
               state_s = TX_IDLE;
            end else begin
               state_s = TX_WAIT;
            end
         end
         default: begin
            state_s   = TX_IDLE;
            pending_s = 1'b0;
         end
      endcase
      busy_s = (state_s == TX_WAIT) | pending_s;
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= TX_IDLE;
         pending_r <= 1'b0;
         trmt_r    <= 1'b0;
         busy_r    <= 1'b0;
         tx_data_r <= RESP_ACK;
      end else begin
         state_r   <= state_s;
         pending_r <= pending_s;
         trmt_r    <= trmt_s;
         busy_r    <= busy_s;
         tx_data_r <= RESP_ACK;
      end
   end

   assign trmt      = trmt_r;
   assign tx_data   = tx_data_r;
   assign resp_busy = busy_r;

endmodule

// File: rtl/cmd_assembler.sv
// Assembles two UART bytes (high first) into a 16-bit command with a level
// cmd_rdy handshake, drops stale half commands, and drives the response path.
module cmd_assembler
   import cmd_assembler_pkg::*;
#(
   parameter int         FAST_SIM     = 1,
   parameter int         TIMEOUT_FAST = 4096,
   parameter int         TIMEOUT_SLOW = 2500000,
   parameter logic [7:0] RESP_ACK     = RESP_ACK_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic        trmt,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        resp_busy,
   output logic        frame_err,
   output logic        overrun
);

   localparam int TIMEOUT = (FAST_SIM != 0) ? TIMEOUT_FAST : TIMEOUT_SLOW;
   localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   rx_state_t         rx_state_r, rx_state_s;
   logic [7:0]        hi_byte_r, hi_byte_s;
   logic [CNT_W-1:0]  tmo_cnt_r, tmo_cnt_s;
   logic [15:0]       cmd_r, cmd_s;
   logic              cmd_rdy_r, cmd_rdy_s;
   logic              clr_rx_rdy_r, clr_rx_rdy_s;
   logic              frame_err_r, frame_err_s;
   logic              overrun_r, overrun_s;
   logic              rx_take_s;

   // Rx next-state logic; a byte still flagged during its own clr_rx_rdy cycle
   // has already been consumed and is not taken again.
   always_comb begin
      rx_take_s    = rx_rdy & ~clr_rx_rdy_r;
      rx_state_s   = rx_state_r;
      hi_byte_s    = hi_byte_r;
      tmo_cnt_s    = tmo_cnt_r;
      cmd_s        = cmd_r;
      cmd_rdy_s    = clr_cmd_rdy ? 1'b0 : cmd_rdy_r;
      clr_rx_rdy_s = 1'b0;
      frame_err_s  = 1'b0;
      overrun_s    = 1'b0;
      case (rx_state_r)
         WAIT_HI: begin
            if (rx_take_s) begin
               hi_byte_s    = rx_data;
               tmo_cnt_s    = {CNT_W{1'b0}};
               cmd_rdy_s    = 1'b0;
               clr_rx_rdy_s = 1'b1;
               rx_state_s   = WAIT_LO;
            end else begin
               rx_state_s   = WAIT_HI;
            end
         end
         WAIT_LO: begin
            if (rx_take_s) begin
               cmd_s        = {hi_byte_r, rx_data};
               cmd_rdy_s    = 1'b1;
               overrun_s    = cmd_rdy_r;
               clr_rx_rdy_s = 1'b1;
               tmo_cnt_s    = {CNT_W{1'b0}};
               rx_state_s   = WAIT_HI;
            end else if (tmo_cnt_r == CNT_LAST) begin
               frame_err_s  = 1'b1;
               hi_byte_s    = 8'h00;
               tmo_cnt_s    = {CNT_W{1'b0}};
               rx_state_s   = WAIT_HI;
            end else begin
               tmo_cnt_s    = tmo_cnt_r + CNT_W'(1);
               rx_state_s   = WAIT_LO;
            end
         end
         default: begin
            rx_state_s = WAIT_HI;
            tmo_cnt_s  = {CNT_W{1'b0}};
         end
      endcase
   end

   // Rx state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_r   <= WAIT_HI;
         hi_byte_r    <= 8'h00;
         tmo_cnt_r    <= {CNT_W{1'b0}};
         cmd_r        <= 16'h0000;
         cmd_rdy_r    <= 1'b0;
         clr_rx_rdy_r <= 1'b0;
         frame_err_r  <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         rx_state_r   <= rx_state_s;
         hi_byte_r    <= hi_byte_s;
         tmo_cnt_r    <= tmo_cnt_s;
         cmd_r        <= cmd_s;
         cmd_rdy_r    <= cmd_rdy_s;
         clr_rx_rdy_r <= clr_rx_rdy_s;
         frame_err_r  <= frame_err_s;
         overrun_r    <= overrun_s;
      end
   end

   assign clr_rx_rdy = clr_rx_rdy_r;
   assign cmd        = cmd_r;
   assign cmd_rdy    = cmd_rdy_r;
   assign frame_err  = frame_err_r;
   assign overrun    = overrun_r;

   resp_tx_ctrl #(
      .RESP_ACK (RESP_ACK)
   ) u_resp_tx (
      .clk       (clk),
      .rst       (rst),
      .send_resp (send_resp),
      .tx_done   (tx_done),
      .trmt      (trmt),
      .tx_data   (tx_data),
      .resp_busy (resp_busy)
   );

endmodule

// File: tb/tb_cmd_assembler.sv
// Self-checking bench for cmd_assembler: directed vectors plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_cmd_assembler;
   import cmd_assembler_pkg::*;

   localparam int TMO = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_rdy = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        clr_rx_rdy;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic        send_resp = 1'b0;
   logic        trmt;
   logic [7:0]  tx_data;
   logic        tx_done = 1'b0;
   logic        resp_busy;
   logic        frame_err;
   logic        overrun;

   always #5 clk = ~clk;

   cmd_assembler #(
      .FAST_SIM(1), .TIMEOUT_FAST(TMO), .TIMEOUT_SLOW(2500000), .RESP_ACK(8'hA5)
   ) dut (
      .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
      .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
      .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .resp_busy(resp_busy),
      .frame_err(frame_err), .overrun(overrun)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: partial command as a byte plus arrival cycle, tx as a
   // flight flag plus owed-request count.
   int          ncyc = 0;
   bit          m_part_valid, m_consumed, m_cmd_rdy, m_clr, m_ferr, m_ovr;
   logic [7:0]  m_hi;
   int          m_t_hi;
   logic [15:0] m_cmd;
   bit          m_in_flight, m_trmt;
   int          m_owed;

   // UART-side stand-ins owned by the bench.
   bit drop_pend = 1'b0;
   int done_cnt = 0;
   int done_delay = 4;
   int clr_pulses = 0, ferr_pulses = 0, trmt_pulses = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   task automatic model_reset();
      m_part_valid = 1'b0; m_consumed = 1'b1; m_cmd_rdy = 1'b0; m_clr = 1'b0;
      m_ferr = 1'b0; m_ovr = 1'b0; m_hi = 8'h00; m_t_hi = 0; m_cmd = 16'h0000;
      m_in_flight = 1'b0; m_trmt = 1'b0; m_owed = 0;
   endtask

   task automatic model_edge();
      bit take;
      if (rst) begin
         model_reset();
         return;
      end
      ncyc++;
      m_clr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_trmt = 1'b0;
      take = rx_rdy && !m_consumed;
      if (take) begin
         m_consumed = 1'b1;
         m_clr = 1'b1;
         if (!m_part_valid) begin
            m_part_valid = 1'b1; m_hi = rx_data; m_t_hi = ncyc; m_cmd_rdy = 1'b0;
         end else begin
            m_ovr = m_cmd_rdy;
            m_cmd = {m_hi, rx_data};
            m_cmd_rdy = 1'b1;
            m_part_valid = 1'b0;
         end
      end else begin
         if (m_part_valid && (ncyc - m_t_hi == TMO)) begin
            m_ferr = 1'b1;
            m_part_valid = 1'b0;
         end
         if (clr_cmd_rdy) m_cmd_rdy = 1'b0;
      end
      if (!m_in_flight) begin
         if (send_resp || m_owed > 0) begin
            m_trmt = 1'b1; m_in_flight = 1'b1; m_owed = 0;
         end
      end else begin
         if (send_resp) m_owed = 1;
         if (tx_done) m_in_flight = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("cmd", 32'(cmd), 32'(m_cmd));
      chk("cmd_rdy", 32'(cmd_rdy), 32'(m_cmd_rdy));
      chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(m_clr));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("trmt", 32'(trmt), 32'(m_trmt));
      chk("tx_data", 32'(tx_data), 32'h0000_00A5);
      chk("resp_busy", 32'(resp_busy), 32'(m_in_flight || (m_owed > 0)));
      if (clr_rx_rdy) clr_pulses++;
      if (frame_err) ferr_pulses++;
      if (trmt) trmt_pulses++;
      send_resp = 1'b0;
      clr_cmd_rdy = 1'b0;
      if (drop_pend) begin
         rx_rdy = 1'b0;
         drop_pend = 1'b0;
      end
      if (clr_rx_rdy) drop_pend = 1'b1;
      tx_done = 1'b0;
      if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0) tx_done = 1'b1;
      end
      if (trmt) done_cnt = done_delay;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_rdy = 1'b0; drop_pend = 1'b0; tx_done = 1'b0; done_cnt = 0;
      send_resp = 1'b0; clr_cmd_rdy = 1'b0;
      model_reset();
      #1;
      chk("rst_cmd", 32'(cmd), 32'h0);
      chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
      chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'h0);
      chk("rst_trmt", 32'(trmt), 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'hA5);
      chk("rst_resp_busy", 32'(resp_busy), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic present_byte(input logic [7:0] b);
      int n = 0;
      while ((rx_rdy || drop_pend) && n < 8) begin
         tick();
         n++;
      end
      if (rx_rdy) begin
         bound_fail("rx_release");
         rx_rdy = 1'b0;
         drop_pend = 1'b0;
      end
      rx_data = b;
      rx_rdy = 1'b1;
      m_consumed = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      present_byte(b);
      tick();
   endtask

   typedef struct {
      logic [7:0]  hi;
      logic [7:0]  lo;
      int          gap;
      bit          clr_same;
      logic [15:0] exp_cmd;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [15:0] prev;
      int c0, f0, t0, n;
      bit any_rdy;

      vecs[0] = '{{OP_MOVE, 4'h3},    {OP_TOUR, 4'h2}, 100, 1'b0, 16'h2342};
      vecs[1] = '{{OP_TOUR, 4'h0},    8'h00,           3,   1'b0, 16'h4000};
      vecs[2] = '{{OP_TOUR, 4'h0},    8'h00,           0,   1'b1, 16'h4000};
      vecs[3] = '{{OP_MOVE_FF, 4'hF}, 8'h81,           5,   1'b1, 16'h3F81};
      vecs[4] = '{{OP_CAL, 4'h7},     8'hC3,           2,   1'b0, 16'h07C3};

      model_reset();
      #2;
      do_reset();

      // Table-driven two-byte commands, cmd_rdy checked one cycle after the low byte.
      prev = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         c0 = clr_pulses;
         send_byte(vecs[i].hi);
         chk("vec_hi_rdy_drop", 32'(cmd_rdy), 32'h0);
         chk("vec_hi_cmd_hold", 32'(cmd), 32'(prev));
         repeat (vecs[i].gap) tick();
         present_byte(vecs[i].lo);
         clr_cmd_rdy = vecs[i].clr_same;
         chk("vec_pre_rdy", 32'(cmd_rdy), 32'h0);
         tick();
         chk("vec_cmd", 32'(cmd), 32'(vecs[i].exp_cmd));
         chk("vec_rdy", 32'(cmd_rdy), 32'h1);
         chk("vec_overrun", 32'(overrun), 32'h0);
         chk("vec_clr_pulses", 32'(clr_pulses - c0), 32'h2);
         prev = vecs[i].exp_cmd;
      end

      // Half command left to time out.
      send_byte(8'h20);
      f0 = ferr_pulses;
      any_rdy = 1'b0;
      for (int k = 1; k <= TMO + 5; k++) begin
         tick();
         if (k == TMO) chk("tmo_ferr_at", 32'(frame_err), 32'h1);
         if (cmd_rdy) any_rdy = 1'b1;
      end
      chk("tmo_ferr_count", 32'(ferr_pulses - f0), 32'h1);
      chk("tmo_rdy_low", 32'(any_rdy), 32'h0);
      send_byte(8'h00);
      send_byte(8'h00);
      chk("tmo_next_cmd", 32'(cmd), 32'h0);
      chk("tmo_next_rdy", 32'(cmd_rdy), 32'h1);

      // Low byte arriving in the very cycle the timeout would fire.
      send_byte(8'h31);
      f0 = ferr_pulses;
      repeat (TMO - 1) tick();
      present_byte(8'h55);
      tick();
      chk("late_cmd", 32'(cmd), 32'h3155);
      chk("late_rdy", 32'(cmd_rdy), 32'h1);
      chk("late_ferr", 32'(ferr_pulses - f0), 32'h0);

      // Response path: one pending request, a third is dropped.
      done_delay = 20;
      t0 = trmt_pulses;
      send_resp = 1'b1;
      tick();
      chk("tx_trmt", 32'(trmt), 32'h1);
      chk("tx_ack", 32'(tx_data), 32'hA5);
      chk("tx_busy", 32'(resp_busy), 32'h1);
      repeat (3) tick();
      send_resp = 1'b1;
      tick();
      tick();
      send_resp = 1'b1;
      tick();
      repeat (60) tick();
      chk("tx_trmt_total", 32'(trmt_pulses - t0), 32'h2);
      chk("tx_idle_busy", 32'(resp_busy), 32'h0);

      // send_resp coinciding with tx_done.
      t0 = trmt_pulses;
      send_resp = 1'b1;
      tick();
      n = 0;
      while (!tx_done && n < 40) begin
         tick();
         n++;
      end
      if (!tx_done) bound_fail("tx_done_wait");
      send_resp = 1'b1;
      tick();
      repeat (40) tick();
      chk("tx_done_same", 32'(trmt_pulses - t0), 32'h2);
      chk("tx_done_same_idle", 32'(resp_busy), 32'h0);

      // Reset with a half command and a pending response outstanding.
      done_delay = 30;
      send_resp = 1'b1;
      tick();
      tick();
      send_resp = 1'b1;
      tick();
      send_byte(8'h42);
      #3;
      do_reset();
      t0 = trmt_pulses;
      send_byte(8'h02);
      send_byte(8'h20);
      chk("post_rst_cmd", 32'(cmd), 32'h0220);
      chk("post_rst_rdy", 32'(cmd_rdy), 32'h1);
      repeat (30) tick();
      chk("post_rst_no_trmt", 32'(trmt_pulses - t0), 32'h0);

      // Randomized traffic against the model, with silences long enough to time out.
      for (int seg = 0; seg < 3; seg++) begin
         for (int c = 0; c < 900; c++) begin
            if (!rx_rdy && !drop_pend && $urandom_range(0, 3) == 0) begin
               rx_data = 8'($urandom);
               rx_rdy = 1'b1;
               m_consumed = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) send_resp = 1'b1;
            if ($urandom_range(0, 9) == 0) clr_cmd_rdy = 1'b1;
            done_delay = $urandom_range(1, 8);
            tick();
         end
         if (seg < 2) begin
            repeat (TMO - 2 + $urandom_range(0, 3)) tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cmd_assembler.md
Name: cmd_assembler

Overview:
- Sits directly upstream of the command processor, between the byte-level UART transceiver and the processor's cmd/cmd_rdy/clr_cmd_rdy interface.
- Assembles two received bytes (high byte first) into the 16-bit command word and presents it with a level cmd_rdy handshake.
- Drops a stale half-received command after an inter-byte timeout.
- Turns the processor's send_resp pulse into a single-byte acknowledge transmission, with one-deep pending buffering.

Parameters:
FAST_SIM, 1, selects the short inter-byte timeout for simulation.
TIMEOUT_FAST, 4096, inter-byte timeout in clk cycles when FAST_SIM=1.
TIMEOUT_SLOW, 2500000, inter-byte timeout in clk cycles when FAST_SIM=0 (50 ms at 50 MHz).
RESP_ACK, 8'hA5, byte transmitted for each response.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
rx_rdy  in  1  UART has a received byte in rx_data (level, held until cleared)
rx_data  in  8  received byte
clr_rx_rdy  out  1  one-cycle pulse acknowledging the consumed byte
cmd  out  16  assembled command {high byte, low byte}
cmd_rdy  out  1  command valid (level)
clr_cmd_rdy  in  1  processor consumed the command
send_resp  in  1  one-cycle request to send the acknowledge
trmt  out  1  one-cycle pulse starting a UART transmission
tx_data  out  8  byte to transmit, equal to RESP_ACK
tx_done  in  1  UART finished the current transmission (pulse or level)
resp_busy  out  1  transmission in flight or pending
frame_err  out  1  one-cycle pulse when a partial command times out
overrun  out  1  one-cycle pulse when a new command overwrites an unconsumed one

Behaviour:
Reset values: cmd=0, cmd_rdy=0, clr_rx_rdy=0, trmt=0, tx_data=RESP_ACK, resp_busy=0, frame_err=0, overrun=0, rx FSM in WAIT_HI, tx FSM in TX_IDLE, timeout counter=0, pending=0. Reset mid-operation discards any partial byte and any pending response.

Rx FSM, states WAIT_HI and WAIT_LO. All outputs are registered.
- WAIT_HI with rx_rdy=1: latch rx_data into hi_byte, pulse clr_rx_rdy next cycle, clear the timeout counter, go to WAIT_LO. cmd_rdy is cleared on this same edge (a new command has started). cmd keeps its previous value.
- WAIT_LO with rx_rdy=1: on the next edge cmd={hi_byte,rx_data} and cmd_rdy=1, clr_rx_rdy pulses, state goes to WAIT_HI. Latency is 1 cycle from low-byte rx_rdy to cmd_rdy.
- While in WAIT_LO the timeout counter increments every cycle.
- When the counter reaches TIMEOUT-1 with no rx_rdy: pulse frame_err, discard hi_byte, return to WAIT_HI. If rx_rdy arrives in that same cycle, the byte is accepted and there is no error.
- Counter width is the clog2 of the selected timeout. It saturates and never wraps.
- clr_cmd_rdy clears cmd_rdy on the next edge.
- clr_cmd_rdy asserted in the same cycle as a low-byte completion: the set wins, so cmd_rdy=1 with the new cmd.
- Low byte completes while cmd_rdy is still 1: cmd is overwritten and overrun pulses.
- cmd changes only at completion and is stable while cmd_rdy=1.
- rx_rdy must already be low the cycle after clr_rx_rdy. A byte is consumed at most once per clr_rx_rdy pulse.

Tx FSM, states TX_IDLE and TX_WAIT.
- TX_IDLE with send_resp=1 or pending=1: pulse trmt for one cycle on the next edge, clear pending, go to TX_WAIT.
- TX_WAIT: return to TX_IDLE on tx_done.
- send_resp in TX_WAIT sets pending (one deep). Further send_resp while pending=1 is ignored.
- send_resp in the same cycle as tx_done in TX_WAIT sets pending, so exactly one further trmt follows.
- resp_busy = (state==TX_WAIT) | pending.
- The rx and tx paths are independent and operate concurrently.

Decomposition:
- Shared package holds:
  - rx_state_t enum {WAIT_HI, WAIT_LO}
  - tx_state_t enum {TX_IDLE, TX_WAIT}
  - the RESP_ACK default constant
  - the command opcode constants (CAL=4'h0, MOVE=4'h2, MOVE_FF=4'h3, TOUR=4'h4), shared with the processor.
- One natural sub-module, resp_tx_ctrl, containing the tx FSM and pending flag. The rx assembly and timeout stay in the top.

Test Plan:
- Reset, then bytes 8'h23 and 8'h42 delivered 100 cycles apart -> cmd=16'h2342, cmd_rdy=1 exactly one cycle after the second rx_rdy, and two clr_rx_rdy pulses.
- Byte 8'h20, then silence for TIMEOUT_FAST cycles -> frame_err pulses once, cmd_rdy stays 0. Then bytes 8'h00, 8'h00 -> cmd=16'h0000, cmd_rdy=1.
- Command completes and clr_cmd_rdy is withheld, then a second pair 8'h40,8'h00 arrives:
  - cmd_rdy drops when 8'h40 is received.
  - cmd=16'h4000 and cmd_rdy=1 after 8'h00.
  - no overrun.
  - Repeat with clr_cmd_rdy asserted in the completion cycle -> cmd_rdy stays 1.
- send_resp pulse -> trmt pulses with tx_data=8'hA5 and resp_busy=1. A second send_resp before tx_done -> exactly one more trmt after tx_done. A third send_resp while pending -> no extra trmt.
- Assert rst mid-way through a command, after the high byte -> outputs return to reset values immediately. A following full 2-byte command assembles correctly.
